// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - round-robin two-requester character write arbiter for lcd_driver
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   init_done           driver init complete; gates new grants only
//   req[1:0]            per-requester request, held until ack
//   req_row/col/char    per-requester target row, column (4b), character (8b)
//   ack[1:0]            one-cycle completion pulse to the granted requester
//   drv_start/rs/db     one-cycle byte strobe, command(0)/data(1), byte to lcd_driver
//   drv_done            driver transfer complete pulse
//   busy                high whenever not idle
//   timeout_err         sticky drv_done timeout flag

module lcd_write_arbiter #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic [1:0]  req,
   input  logic [1:0]  req_row,
   input  logic [7:0]  req_col,
   input  logic [15:0] req_char,
   output logic [1:0]  ack,
   output logic        drv_start,
   output logic        drv_rs,
   output logic [7:0]  drv_db,
   input  logic        drv_done,
   output logic        busy,
   output logic        timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_ISSUE,
      S_ADDR_WAIT,
      S_DATA_ISSUE,
      S_DATA_WAIT,
      S_ACK
   } state_t;

   state_t           state;
   logic             ptr;
   logic             grant;
   logic [6:0]       addr_q;
   logic [7:0]       char_q;
   logic [6:0]       cursor;
   logic             cursor_valid;
   logic [CNT_W-1:0] cnt;

   logic       sel;
   logic       sel_row;
   logic [3:0] sel_col;
   logic [7:0] sel_char;
   logic [6:0] sel_addr;
   logic       sel_skip;

   // Favoured requester wins a tie; otherwise the only active requester wins.
   always_comb begin
      sel = 1'b0;
      if (req == 2'b11) begin
         sel = ptr;
      end else begin
         sel = req[1];
      end
      sel_row  = sel ? req_row[1]      : req_row[0];
      sel_col  = sel ? req_col[7:4]    : req_col[3:0];
      sel_char = sel ? req_char[15:8]  : req_char[7:0];
      // DDRAM address: row 1 starts at 0x40, so the row bit lands on bit 6.
      sel_addr = {sel_row, 2'b00, sel_col};
      sel_skip = cursor_valid && (cursor == sel_addr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         ack          <= 2'b00;
         drv_start    <= 1'b0;
         drv_rs       <= 1'b0;
         drv_db       <= 8'h00;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
         ptr          <= 1'b0;
         grant        <= 1'b0;
         addr_q       <= 7'h00;
         char_q       <= 8'h00;
         cursor       <= 7'h00;
         cursor_valid <= 1'b0;
         cnt          <= '0;
      end else begin
         drv_start <= 1'b0;
         ack       <= 2'b00;
         case (state)
            S_IDLE: begin
               if (init_done && (|req)) begin
                  grant     <= sel;
                  addr_q    <= sel_addr;
                  char_q    <= sel_char;
                  busy      <= 1'b1;
                  drv_start <= 1'b1;
                  if (sel_skip) begin
                     state  <= S_DATA_ISSUE;
                     drv_rs <= 1'b1;
                     drv_db <= sel_char;
                  end else begin
                     state  <= S_ADDR_ISSUE;
                     drv_rs <= 1'b0;
                     drv_db <= {1'b1, sel_addr};
                  end
               end
            end
            S_ADDR_ISSUE: begin
               state <= S_ADDR_WAIT;
               cnt   <= '0;
            end
            S_ADDR_WAIT: begin
               if (drv_done) begin
                  state     <= S_DATA_ISSUE;
                  drv_start <= 1'b1;
                  drv_rs    <= 1'b1;
                  drv_db    <= char_q;
               end else if (cnt == CNT_LAST) begin
                  // Hardware cursor position is unknown after a lost transfer.
                  timeout_err  <= 1'b1;
                  cursor_valid <= 1'b0;
                  state        <= S_ACK;
                  ack          <= grant ? 2'b10 : 2'b01;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA_ISSUE: begin
               state <= S_DATA_WAIT;
               cnt   <= '0;
            end
            S_DATA_WAIT: begin
               if (drv_done) begin
                  // Column 15 auto-increments off the visible row.
                  if (addr_q[3:0] == 4'hF) begin
                     cursor_valid <= 1'b0;
                  end else begin
                     cursor       <= addr_q + 7'd1;
                     cursor_valid <= 1'b1;
                  end
                  state <= S_ACK;
                  ack   <= grant ? 2'b10 : 2'b01;
               end else if (cnt == CNT_LAST) begin
                  timeout_err  <= 1'b1;
                  cursor_valid <= 1'b0;
                  state        <= S_ACK;
                  ack          <= grant ? 2'b10 : 2'b01;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ACK: begin
               ptr   <= ~grant;
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - randomized self-checking bench for lcd_write_arbiter

module tb_lcd_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_done;
   logic [1:0]  req;
   logic [1:0]  req_row;
   logic [7:0]  req_col;
   logic [15:0] req_char;
   logic [1:0]  ack;
   logic        drv_start;
   logic        drv_rs;
   logic [7:0]  drv_db;
   logic        drv_done;
   logic        busy;
   logic        timeout_err;

   lcd_write_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .rst         (rst_n),
      .init_done   (init_done),
      .req         (req),
      .req_row     (req_row),
      .req_col     (req_col),
      .req_char    (req_char),
      .ack         (ack),
      .drv_start   (drv_start),
      .drv_rs      (drv_rs),
      .drv_db      (drv_db),
      .drv_done    (drv_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model: shared LCD cursor and round-robin pointer
   int m_ptr;
   int m_cur;
   bit m_cur_v;

   int obs_q[$];
   int exp_q[$];
   int start_cyc;
   int done_cyc;
   int pending = 0;
   bit no_resp = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver model: logs every strobed byte and answers after a random delay
   initial begin
      drv_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         drv_done = 1'b0;
         if (pending > 0) begin
            pending--;
            if (pending == 0) begin
               drv_done = 1'b1;
               done_cyc = cyc;
            end
         end
         if (drv_start === 1'b1) begin
            obs_q.push_back({23'd0, drv_rs, drv_db});
            start_cyc = cyc;
            if (!no_resp) pending = $urandom_range(1, 5);
         end
      end
   end

   // One arbitration round: call at #1 after an edge with the DUT idle and req != 0.
   task automatic serve(input bit tmo, output int g);
      int row, col, ch, a, n;
      bit skip;
      if (req == 2'b11) g = m_ptr;
      else g = req[1] ? 1 : 0;
      row = req_row[g];
      col = req_col[g*4 +: 4];
      ch  = req_char[g*8 +: 8];
      a   = row * 64 + col;
      skip = m_cur_v && (m_cur == a);
      exp_q.delete();
      obs_q.delete();
      if (!skip) exp_q.push_back(128 + a);
      if (!(tmo && !skip)) exp_q.push_back(256 + ch);

      @(posedge clk);
      #1;
      check_eq("grant_start", drv_start, 1);
      check_eq("grant_busy", busy, 1);
      // fields change after grant must not affect the transfer
      req_row[g] = 1'($urandom);
      req_col[g*4 +: 4] = 4'($urandom);
      req_char[g*8 +: 8] = 8'($urandom);

      n = 0;
      while (ack == 2'b00 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 400) check_eq("ack_wait_expired", 0, 1);
      check_eq("ack_bit", ack, (g == 1) ? 2 : 1);
      if (tmo) check_eq("ack_after_timeout", cyc - start_cyc, 17);
      else check_eq("ack_latency", cyc - done_cyc, 1);
      check_eq("byte_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check_eq("drv_byte", obs_q[i], exp_q[i]);

      req[g] = 1'b0;
      if (tmo) m_cur_v = 1'b0;
      else if (col < 15) begin
         m_cur = a + 1;
         m_cur_v = 1'b1;
      end else m_cur_v = 1'b0;
      m_ptr = 1 - g;

      @(posedge clk);
      #1;
      check_eq("ack_single", ack, 0);
      check_eq("idle_busy", busy, 0);
   endtask

   task automatic set_req(input int i, input int row, input int col, input int ch);
      req_row[i] = 1'(row);
      req_col[i*4 +: 4] = 4'(col);
      req_char[i*8 +: 8] = 8'(ch);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int g, p, k, ack_seen;
      rst_n = 1'b0;
      init_done = 1'b0;
      req = 2'b00;
      req_row = 2'b00;
      req_col = 8'h00;
      req_char = 16'h0000;
      m_ptr = 0;
      m_cur = 0;
      m_cur_v = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ack", ack, 0);
      check_eq("rst_start", drv_start, 0);
      check_eq("rst_rs", drv_rs, 0);
      check_eq("rst_db", drv_db, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_terr", timeout_err, 0);
      rst_n = 1'b1;

      // init_done low blocks grants
      set_req(0, 0, 5, 8'h30);
      set_req(1, 1, 2, 8'h31);
      req = 2'b11;
      obs_q.delete();
      repeat (6) @(posedge clk);
      #1;
      check_eq("noinit_busy", busy, 0);
      check_eq("noinit_bytes", obs_q.size(), 0);

      // arbitration with both held: 0,1,0,1
      init_done = 1'b1;
      serve(0, g); check_eq("rr_0", g, 0);
      serve(0, g); check_eq("rr_1", g, 1);
      set_req(0, 0, 8, 8'h32);
      set_req(1, 0, 9, 8'h33);
      req = 2'b11;
      serve(0, g); check_eq("rr_2", g, 0);
      serve(0, g); check_eq("rr_3", g, 1);

      // single write, cursor skip, column-15 wrap
      set_req(0, 0, 3, 8'h41); req = 2'b01; serve(0, g);
      set_req(0, 0, 4, 8'h42); req = 2'b01; serve(0, g);
      check_eq("skip_one_byte", obs_q.size(), 1);
      set_req(0, 1, 15, 8'h43); req = 2'b01; serve(0, g);
      set_req(0, 1, 0, 8'h44); req = 2'b01; serve(0, g);
      check_eq("wrap_addr_cmd", obs_q.size(), 2);

      // randomized rounds
      for (int r = 0; r < 30; r++) begin
         p = $urandom_range(1, 3);
         for (int i = 0; i < 2; i++) begin
            if (m_cur_v && ($urandom_range(0, 1) == 1))
               set_req(i, m_cur / 64, m_cur % 16, $urandom_range(0, 255));
            else
               set_req(i, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
         end
         req = 2'(p);
         k = 0;
         while (req != 2'b00 && k < 2) begin
            serve(0, g);
            k++;
         end
      end

      // timeout on the address command
      no_resp = 1'b1;
      k = m_cur_v ? ((m_cur % 16) + 1) % 16 : 9;
      set_req(0, 0, k, 8'h55); req = 2'b01;
      serve(1, g);
      check_eq("terr_set", timeout_err, 1);
      no_resp = 1'b0;
      set_req(1, 0, 0, 8'h56); req = 2'b10;
      serve(0, g);
      check_eq("post_tmo_addr", obs_q.size(), 2);
      check_eq("terr_sticky", timeout_err, 1);

      // reset in ADDR_WAIT
      no_resp = 1'b1;
      set_req(0, 1, 7, 8'h57); req = 2'b01;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check_eq("mid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_ack", ack, 0);
      check_eq("arst_start", drv_start, 0);
      check_eq("arst_db", drv_db, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_terr", timeout_err, 0);
      init_done = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      obs_q.delete();
      ack_seen = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (ack != 2'b00) ack_seen = 1;
      end
      check_eq("arst_no_ack", ack_seen, 0);
      check_eq("arst_no_grant", obs_q.size(), 0);
      m_ptr = 0;
      m_cur_v = 1'b0;
      no_resp = 1'b0;
      pending = 0;
      init_done = 1'b1;
      serve(0, g);
      check_eq("post_rst_addr", obs_q.size(), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
